// File: rtl/eth_descrambler_if.sv
// Beat-level bus of the 64b/66b RX descrambler: upstream (i_*) and downstream (o_*) handshakes.
// Signal names are seen from the descrambler; the slave modport is the descrambler side.
interface eth_descrambler_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned HDR_WIDTH  = 2
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic [HDR_WIDTH-1:0]  i_header;
  logic                  i_header_valid;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic [HDR_WIDTH-1:0]  o_header;
  logic                  o_header_valid;
  logic                  o_seeded;

  modport slave (
    input  i_valid, i_data, i_header, i_header_valid, i_ready,
    output o_ready, o_valid, o_data, o_header, o_header_valid, o_seeded
  );

  modport master (
    output i_valid, i_data, i_header, i_header_valid, i_ready,
    input  o_ready, o_valid, o_data, o_header, o_header_valid, o_seeded
  );
endinterface

// File: rtl/eth_descrambler.sv
// Self-synchronous x^58+x^39+1 descrambler for the 64b/66b RX path, with header pass-through,
// seed tracking and an output register plus skid register on the beat handshake.
module eth_descrambler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned HDR_WIDTH  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_descrambler_bypass,
  input  logic             i_resync,
  eth_descrambler_if.slave bus
);
  localparam int unsigned LFSR_W     = 58;
  localparam int unsigned SEED_WORDS = (LFSR_W + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned CNT_W      = $clog2(SEED_WORDS + 1);
  localparam logic [CNT_W-1:0] SEED_MAX = CNT_W'(SEED_WORDS);

  typedef enum logic [1:0] {UNSEEDED, SEEDING, SEEDED} seed_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [HDR_WIDTH-1:0]  hdr;
    logic                  hv;
    logic                  seeded;
  } beat_t;

  seed_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
  beat_t                 out_q, out_d, skid_q, skid_d, beat_in;
  logic                  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic                  accept, seeded_now;
  logic [DATA_WIDTH-1:0] desc;

  // o_ready is skid-empty, a pure register output; nothing from i_ready reaches it.
  assign accept = bus.i_valid & ~skid_vld_q;

  // Whole-beat unrolled descrambler; the LFSR shifts in received bits, MSB first.
  always_comb begin : descramble
    logic [LFSR_W-1:0] s;
    s    = lfsr_q;
    desc = '0;
    for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
      desc[DATA_WIDTH-1-k] = bus.i_data[DATA_WIDTH-1-k] ^ s[38] ^ s[57];
      s = {s[LFSR_W-2:0], bus.i_data[DATA_WIDTH-1-k]};
    end
    lfsr_d = accept ? s : lfsr_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= UNSEEDED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_resync) begin
      cnt_d = accept ? CNT_W'(1) : '0;
    end else if (accept && (cnt_q != SEED_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == '0) begin
      state_d = UNSEEDED;
    end else if (cnt_d == SEED_MAX) begin
      state_d = SEEDED;
    end else begin
      state_d = SEEDING;
    end
  end

  // A beat accepted together with i_resync is seed word 0, never trusted.
  always_comb begin
    seeded_now = (state_q == SEEDED) & ~i_resync;
  end

  always_comb begin
    beat_in.data   = i_descrambler_bypass ? bus.i_data : desc;
    beat_in.hdr    = bus.i_header;
    beat_in.hv     = bus.i_header_valid;
    beat_in.seeded = seeded_now;
  end

  // Skid only fills while the output stalls; it refills the output before new beats.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || bus.i_ready) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = accept;
        if (accept) begin
          out_d = beat_in;
        end
      end
    end else if (accept) begin
      skid_d     = beat_in;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q     <= '1;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.o_ready        = ~skid_vld_q;
  assign bus.o_valid        = out_vld_q;
  assign bus.o_data         = out_q.data;
  assign bus.o_header       = out_q.hdr;
  assign bus.o_header_valid = out_q.hv;
  assign bus.o_seeded       = out_q.seeded;
endmodule

// File: tb/tb_eth_descrambler.sv
// Bench for eth_descrambler: TX scrambler model feeds the DUT; a bit-history reference model
// predicts every accepted beat and scenario tasks compare against it and the plaintext.
module tb_eth_descrambler;
  localparam int W          = 32;
  localparam int SEED_WORDS = (58 + W - 1) / W;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  h;
    logic        hv;
    logic        s;
  } beat_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic bypass = 1'b0;
  logic resync = 1'b0;
  int   checks = 0;
  int   errors = 0;

  eth_descrambler_if #(.DATA_WIDTH(32), .HDR_WIDTH(2)) bus ();

  eth_descrambler #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_descrambler_bypass (bypass),
    .i_resync             (resync),
    .bus                  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: each output bit is the received bit XOR the received bits 39 and 58 back.
  beat_t       got_q[$];
  beat_t       exp_q[$];
  bit          m_hist[$];
  int          m_cnt;
  logic [31:0] m_out;
  logic        m_flag;
  logic        m_bit;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_hist.delete();
      repeat (58) m_hist.push_back(1'b1);
      m_cnt = 0;
      got_q.delete();
      exp_q.delete();
    end else begin
      if (bus.o_valid && bus.i_ready)
        got_q.push_back({bus.o_data, bus.o_header, bus.o_header_valid, bus.o_seeded});
      if (bus.i_valid && bus.o_ready) begin
        for (int i = W - 1; i >= 0; i--) begin
          m_bit    = bus.i_data[i];
          m_out[i] = bypass ? m_bit : (m_bit ^ m_hist[m_hist.size() - 39] ^ m_hist[m_hist.size() - 58]);
          m_hist.push_back(m_bit);
          void'(m_hist.pop_front());
        end
        if (resync) begin
          m_flag = 1'b0;
          m_cnt  = 1;
        end else begin
          m_flag = (m_cnt == SEED_WORDS);
          if (m_cnt < SEED_WORDS) m_cnt++;
        end
        exp_q.push_back({m_out, bus.i_header, bus.i_header_valid, m_flag});
      end else if (resync) begin
        m_cnt = 0;
      end
    end
  end

  // TX scrambler model: scrambled bit is data XOR transmitted bits 39 and 58 back.
  bit          tx_hist[$];
  logic [31:0] pt_q[$];
  logic [31:0] sc_q[$];

  task automatic tx_reset();
    tx_hist.delete();
    repeat (58) tx_hist.push_back(1'b1);
  endtask

  task automatic scramble(input logic [31:0] d, output logic [31:0] s);
    for (int i = 31; i >= 0; i--) begin
      s[i] = d[i] ^ tx_hist[tx_hist.size() - 39] ^ tx_hist[tx_hist.size() - 58];
      tx_hist.push_back(s[i]);
      void'(tx_hist.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n              = 1'b0;
    bus.i_valid        = 1'b0;
    bus.i_data         = '0;
    bus.i_header       = '0;
    bus.i_header_valid = 1'b0;
    bus.i_ready        = 1'b1;
    bypass             = 1'b0;
    resync             = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic send_beat(input logic [31:0] d, input logic byp, input logic rs, output bit ok);
    bus.i_valid        = 1'b1;
    bus.i_data         = d;
    bus.i_header       = 2'($urandom_range(0, 3));
    bus.i_header_valid = 1'($urandom_range(0, 1));
    bypass             = byp;
    resync             = rs;
    ok                 = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = bus.o_ready;
      tick();
    end
    bus.i_valid = 1'b0;
    bypass      = 1'b0;
    resync      = 1'b0;
  endtask

  task automatic run_stream(input int n, input int byp_at, input int rs_at, output bit ok);
    logic [31:0] d, s;
    bit a;
    pt_q.delete();
    sc_q.delete();
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      d = $urandom;
      scramble(d, s);
      pt_q.push_back(d);
      sc_q.push_back(s);
      send_beat(s, 1'(k == byp_at), 1'(k == rs_at), a);
      ok &= a;
    end
  endtask

  task automatic drain(output bit ok);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    ok          = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      ok = !bus.o_valid && (got_q.size() == exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [36:0] rst_vec;
    apply_reset();
    checks++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_handshake got %b exp 01", {bus.o_valid, bus.o_ready});
    end
    checks++;
    if ({bus.o_data, bus.o_header, bus.o_header_valid, bus.o_seeded} !== 36'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {bus.o_data, bus.o_header, bus.o_header_valid, bus.o_seeded});
    end
    // Fill output and skid, then reset asynchronously between edges.
    bus.i_ready        = 1'b0;
    bus.i_valid        = 1'b1;
    bus.i_data         = $urandom;
    bus.i_header       = 2'b11;
    bus.i_header_valid = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    checks++;
    if ({bus.o_valid, bus.o_ready} !== 2'b10) begin
      errors++; $display("FAIL midop_full got %b exp 10", {bus.o_valid, bus.o_ready});
    end
    #1 rst_n = 1'b0;
    #1;
    rst_vec = {bus.o_valid, bus.o_data, bus.o_header, bus.o_header_valid, bus.o_seeded};
    checks++;
    if (rst_vec !== 37'h0) begin
      errors++; $display("FAIL midop_reset_outputs got %h exp 0", rst_vec);
    end
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++; $display("FAIL midop_reset_ready got %b exp 1", bus.o_ready);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    begin
      bit a, ok;
      send_beat(32'hFFFF_FFFF, 1'b0, 1'b0, a);
      drain(ok);
      checks++;
      if (!(a && ok && got_q.size() == 1)) begin
        errors++; $display("FAIL post_reset_count got %0d exp 1", got_q.size());
      end else begin
        checks++;
        if ({got_q[0].d, got_q[0].s} !== {32'hFFFF_FFFF, 1'b0}) begin
          errors++; $display("FAIL post_reset_lfsr got %h/%b exp ffffffff/0", got_q[0].d, got_q[0].s);
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [36:0] v;
    apply_reset();
    bus.i_valid        = 1'b1;
    bus.i_data         = 32'hFFFF_FFFF;
    bus.i_header       = 2'b10;
    bus.i_header_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL basic_no_early_valid got %b exp 0", bus.o_valid);
    end
    tick();
    bus.i_data         = 32'h0000_0000;
    bus.i_header       = 2'b01;
    bus.i_header_valid = 1'b0;
    @(negedge clk);
    v = {bus.o_valid, bus.o_data, bus.o_header, bus.o_header_valid, bus.o_seeded};
    checks++;
    if (v !== {1'b1, 32'hFFFF_FFFF, 2'b10, 1'b1, 1'b0}) begin
      errors++; $display("FAIL basic_ones got %h exp %h", v, {1'b1, 32'hFFFF_FFFF, 2'b10, 1'b1, 1'b0});
    end
    tick();
    bus.i_valid = 1'b0;
    @(negedge clk);
    v = {bus.o_valid, bus.o_data, bus.o_header, bus.o_header_valid, bus.o_seeded};
    checks++;
    if (v !== {1'b1, 32'h0, 2'b01, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_zeros got %h exp %h", v, {1'b1, 32'h0, 2'b01, 1'b0, 1'b0});
    end
    tick();
  endtask

  task automatic test_loopback();
    bit ok, dok;
    apply_reset();
    tx_reset();
    run_stream(1000, -1, -1, ok);
    drain(dok);
    checks++;
    if (!(ok && dok && got_q.size() == 1000)) begin
      errors++; $display("FAIL loopback_count got %0d exp 1000 (accept %b drain %b)", got_q.size(), ok, dok);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size() && k < pt_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL loopback_model[%0d] got %h exp %h", k, got_q[k], exp_q[k]);
      end
      checks++;
      if (got_q[k].d !== pt_q[k]) begin
        errors++; $display("FAIL loopback_data[%0d] got %h exp %h", k, got_q[k].d, pt_q[k]);
      end
      checks++;
      if (got_q[k].s !== 1'(k >= 2)) begin
        errors++; $display("FAIL loopback_seeded[%0d] got %b exp %b", k, got_q[k].s, k >= 2);
      end
    end
  endtask

  task automatic test_late_start();
    logic [31:0] d, s;
    bit a, ok, dok;
    apply_reset();
    tx_reset();
    for (int k = 0; k < 37; k++) begin
      d = $urandom;
      scramble(d, s);
    end
    for (int k = 0; k < 5; k++) send_beat($urandom, 1'b0, 1'b0, a);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    run_stream(20, -1, -1, ok);
    drain(dok);
    checks++;
    if (!(ok && dok && got_q.size() == 25)) begin
      errors++; $display("FAIL late_count got %0d exp 25", got_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL late_model[%0d] got %h exp %h", k, got_q[k], exp_q[k]);
      end
    end
    for (int k = 0; k < 20 && (k + 5) < got_q.size(); k++) begin
      checks++;
      if (got_q[k+5].s !== 1'(k >= 2)) begin
        errors++; $display("FAIL late_seeded[%0d] got %b exp %b", k, got_q[k+5].s, k >= 2);
      end
      if (k >= 2) begin
        checks++;
        if (got_q[k+5].d !== pt_q[k]) begin
          errors++; $display("FAIL late_data[%0d] got %h exp %h", k, got_q[k+5].d, pt_q[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, s;
    logic [36:0] snap, prev;
    bit prev_stall, prev_wait, acc, dok;
    int sent;
    prev_stall = 1'b0;
    prev_wait  = 1'b0;
    sent       = 0;
    prev       = '0;
    apply_reset();
    tx_reset();
    pt_q.delete();
    d = $urandom;
    scramble(d, s);
    pt_q.push_back(d);
    bus.i_valid        = 1'b1;
    bus.i_data         = s;
    bus.i_header       = 2'($urandom_range(0, 3));
    bus.i_header_valid = 1'($urandom_range(0, 1));
    for (int c = 0; c < 5000 && sent < 300; c++) begin
      bus.i_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      snap = {bus.o_valid, bus.o_data, bus.o_header, bus.o_header_valid, bus.o_seeded};
      if (prev_stall) begin
        checks++;
        if (snap !== prev) begin
          errors++; $display("FAIL bp_stable cycle %0d got %h exp %h", c, snap, prev);
        end
      end
      if (prev_wait) begin
        checks++;
        if (bus.o_ready !== 1'b1) begin
          errors++; $display("FAIL bp_ready_recover cycle %0d got %b exp 1", c, bus.o_ready);
        end
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_wait  = !bus.o_ready && bus.i_ready;
      prev       = snap;
      acc        = bus.o_ready;
      tick();
      if (acc) begin
        sent++;
        if (sent < 300) begin
          d = $urandom;
          scramble(d, s);
          pt_q.push_back(d);
          bus.i_data         = s;
          bus.i_header       = 2'($urandom_range(0, 3));
          bus.i_header_valid = 1'($urandom_range(0, 1));
        end else begin
          bus.i_valid = 1'b0;
        end
      end
    end
    drain(dok);
    checks++;
    if (!(dok && sent == 300 && got_q.size() == 300)) begin
      errors++; $display("FAIL bp_count got %0d exp 300 (sent %0d)", got_q.size(), sent);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size() && k < pt_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL bp_model[%0d] got %h exp %h", k, got_q[k], exp_q[k]);
      end
      checks++;
      if ({got_q[k].d, got_q[k].s} !== {pt_q[k], 1'(k >= 2)}) begin
        errors++; $display("FAIL bp_data[%0d] got %h/%b exp %h/%b", k, got_q[k].d, got_q[k].s, pt_q[k], k >= 2);
      end
    end
  endtask

  task automatic test_bypass();
    bit ok, dok;
    logic [31:0] want;
    apply_reset();
    tx_reset();
    run_stream(16, 10, -1, ok);
    drain(dok);
    checks++;
    if (!(ok && dok && got_q.size() == 16)) begin
      errors++; $display("FAIL bypass_count got %0d exp 16", got_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size() && k < pt_q.size(); k++) begin
      want = (k == 10) ? sc_q[k] : pt_q[k];
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL bypass_model[%0d] got %h exp %h", k, got_q[k], exp_q[k]);
      end
      checks++;
      if (got_q[k].d !== want) begin
        errors++; $display("FAIL bypass_data[%0d] got %h exp %h", k, got_q[k].d, want);
      end
    end
  endtask

  task automatic test_resync();
    bit ok, dok;
    logic want_s;
    apply_reset();
    tx_reset();
    run_stream(30, -1, 20, ok);
    drain(dok);
    checks++;
    if (!(ok && dok && got_q.size() == 30)) begin
      errors++; $display("FAIL resync_count got %0d exp 30", got_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size() && k < pt_q.size(); k++) begin
      want_s = 1'((k >= 2) && (k != 20) && (k != 21));
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL resync_model[%0d] got %h exp %h", k, got_q[k], exp_q[k]);
      end
      checks++;
      if ({got_q[k].d, got_q[k].s} !== {pt_q[k], want_s}) begin
        errors++; $display("FAIL resync_word[%0d] got %h/%b exp %h/%b", k, got_q[k].d, got_q[k].s, pt_q[k], want_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_late_start();
    test_backpressure();
    test_bypass();
    test_resync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
